// File: rtl/adc_sample_sequencer.sv
// Paced command initiator for the Modular ADC with response checking and a sample FIFO.
// Define ADC_SIGNED_OUT_EN to store samples as two's complement offset from mid-scale.
`timescale 1ns / 1ps

module adc_sample_sequencer #(
  parameter int unsigned SAMPLE_DIV   = 1000,
  parameter logic [4:0]  CHANNEL      = 5'd0,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned RESP_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  output logic        command_startofpacket,
  output logic        command_endofpacket,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  input  logic        sample_ready,
  output logic        overflow,
  output logic        timeout_err,
  output logic        chan_err,
  input  logic        clear_flags
);

  localparam int unsigned PaceW = $clog2(SAMPLE_DIV);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned ToW   = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StCmd, StWait} state_e;

  state_e             state_q, state_d;
  logic [PaceW-1:0]   pace_q;
  logic [ToW-1:0]     timer_q, timer_d;
  logic               tick;
  logic               push, set_timeout, set_chan;

  logic [11:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               full, empty, pop, push_ok, set_ovf;
  logic [11:0]        push_data;
  logic               overflow_q, timeout_q, chan_q;

  assign tick = (pace_q == PaceW'(SAMPLE_DIV - 1));

  // Pace counter free-runs regardless of FSM state; ticks seen outside idle are lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pace_q <= '0;
    end else begin
      pace_q <= tick ? '0 : pace_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    push        = 1'b0;
    set_timeout = 1'b0;
    set_chan    = 1'b0;
    case (state_q)
      StIdle: begin
        if (tick && enable) state_d = StCmd;
      end
      StCmd: begin
        if (command_ready) begin
          state_d = StWait;
          timer_d = '0;
        end
      end
      StWait: begin
        // A response in the final waiting cycle still counts as on time.
        if (response_valid) begin
          state_d  = StIdle;
          push     = 1'b1;
          set_chan = (response_channel != CHANNEL);
        end else if (timer_q == ToW'(RESP_TIMEOUT - 1)) begin
          state_d     = StIdle;
          set_timeout = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign command_valid         = (state_q == StCmd);
  assign command_channel       = command_valid ? CHANNEL : '0;
  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;

`ifdef ADC_SIGNED_OUT_EN
  assign push_data = response_data - 12'd2048;
`else
  assign push_data = response_data;
`endif

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = !empty && sample_ready;
  // A simultaneous pop frees the slot, so a push at full is still accepted.
  assign push_ok = push && (!full || pop);
  assign set_ovf = push && full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push_ok) - CntW'(pop);
    end
  end

  assign sample_valid = !empty;
  assign sample_data  = mem_q[rd_ptr_q];

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      chan_q     <= 1'b0;
    end else begin
      overflow_q <= set_ovf     || (overflow_q && !clear_flags);
      timeout_q  <= set_timeout || (timeout_q && !clear_flags);
      chan_q     <= set_chan    || (chan_q && !clear_flags);
    end
  end

  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;
  assign chan_err    = chan_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer: vector table plus hand-written corner sequences.
`timescale 1ns / 1ps

module tb_adc_sample_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        command_ready = 1'b0;
  logic        response_valid = 1'b0;
  logic [4:0]  response_channel = '0;
  logic [11:0] response_data = '0;
  logic        sample_ready = 1'b0;
  logic        clear_flags = 1'b0;
  logic        command_valid, command_startofpacket, command_endofpacket;
  logic [4:0]  command_channel;
  logic        sample_valid, overflow, timeout_err, chan_err;
  logic [11:0] sample_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  adc_sample_sequencer #(
    .SAMPLE_DIV  (8),
    .CHANNEL     (5'd0),
    .FIFO_DEPTH  (4),
    .RESP_TIMEOUT(20)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .enable               (enable),
    .command_valid        (command_valid),
    .command_channel      (command_channel),
    .command_startofpacket(command_startofpacket),
    .command_endofpacket  (command_endofpacket),
    .command_ready        (command_ready),
    .response_valid       (response_valid),
    .response_channel     (response_channel),
    .response_data        (response_data),
    .sample_valid         (sample_valid),
    .sample_data          (sample_data),
    .sample_ready         (sample_ready),
    .overflow             (overflow),
    .timeout_err          (timeout_err),
    .chan_err             (chan_err),
    .clear_flags          (clear_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us, expected completion");
    $fatal(1);
  end

  function automatic logic [11:0] conv(input logic [11:0] raw);
`ifdef ADC_SIGNED_OUT_EN
    return raw - 12'd2048;
`else
    return raw;
`endif
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cmd(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      if (command_valid === 1'b1) begin
        at = cycle;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (at < 0) begin
      n_fail++;
      $display("FAIL cmd_wait: command_valid got 0 for 40 cycles, expected 1");
    end
  endtask

  // Accept a command (command_ready assumed high), answer 3 cycles later for one cycle.
  task automatic do_txn(input logic [4:0] ch, input logic [11:0] data, input logic keep_en,
                        input logic clr, input logic pop, output int at);
    wait_cmd(at);
    enable = keep_en;
    repeat (3) @(negedge clk);
    response_channel = ch;
    response_data    = data;
    response_valid   = 1'b1;
    clear_flags      = clr;
    sample_ready     = pop;
    @(negedge clk);
    response_valid = 1'b0;
    clear_flags    = 1'b0;
    sample_ready   = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [11:0] exp);
    chk1({name, "_valid"}, sample_valid, 1'b1);
    chk12({name, "_data"}, sample_data, exp);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  ch;
    logic [11:0] data;
    logic [11:0] exp_data;
    logic        exp_chan;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t0, t1;
    logic [11:0] d;

    vecs[0] = '{ch: 5'd0,  data: 12'h123, exp_data: conv(12'h123), exp_chan: 1'b0};
    vecs[1] = '{ch: 5'd3,  data: 12'h456, exp_data: conv(12'h456), exp_chan: 1'b1};
    vecs[2] = '{ch: 5'd0,  data: 12'h800, exp_data: conv(12'h800), exp_chan: 1'b0};
    vecs[3] = '{ch: 5'd0,  data: 12'h000, exp_data: conv(12'h000), exp_chan: 1'b0};
    vecs[4] = '{ch: 5'd31, data: 12'hFFF, exp_data: conv(12'hFFF), exp_chan: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_cmd_valid", command_valid, 1'b0);
    chk1("rst_sop", command_startofpacket, 1'b0);
    chk1("rst_eop", command_endofpacket, 1'b0);
    chk1("rst_sample_valid", sample_valid, 1'b0);
    chk12("rst_sample_data", sample_data, 12'h000);
    chk1("rst_overflow", overflow, 1'b0);
    chk1("rst_timeout", timeout_err, 1'b0);
    chk1("rst_chan_err", chan_err, 1'b0);

    // Basic pacing: one command per 8 clocks, sample visible the cycle after the response
    reset_n       = 1'b1;
    command_ready = 1'b1;
    enable        = 1'b1;
    wait_cmd(t0);
    chk1("cmd_sop", command_startofpacket, 1'b1);
    chk1("cmd_eop", command_endofpacket, 1'b1);
    @(negedge clk);
    chk1("cmd_drop_after_accept", command_valid, 1'b0);
    repeat (2) @(negedge clk);
    chk1("no_sample_before_resp", sample_valid, 1'b0);
    response_channel = 5'd0;
    response_data    = 12'hABC;
    response_valid   = 1'b1;
    @(negedge clk);
    response_valid = 1'b0;
    pop_chk("t1_first", conv(12'hABC));
    do_txn(5'd0, 12'hABC, 1'b0, 1'b0, 1'b0, t1);
    chk12("t1_period", 12'(t1 - t0), 12'd8);
    pop_chk("t1_second", conv(12'hABC));
    chk1("t1_empty", sample_valid, 1'b0);

    // Table: data path and channel check
    for (int i = 0; i < 5; i++) begin
      enable = 1'b1;
      do_txn(vecs[i].ch, vecs[i].data, 1'b0, 1'b0, 1'b0, t0);
      chk1($sformatf("vec%0d_chan_err", i), chan_err, vecs[i].exp_chan);
      pop_chk($sformatf("vec%0d", i), vecs[i].exp_data);
      if (vecs[i].exp_chan) begin
        pulse_clear();
        chk1($sformatf("vec%0d_chan_cleared", i), chan_err, 1'b0);
      end
    end

    // Clear coinciding with a new channel error: error wins
    enable = 1'b1;
    do_txn(5'd3, 12'h321, 1'b0, 1'b1, 1'b0, t0);
    chk1("clr_vs_set_chan", chan_err, 1'b1);
    pop_chk("clr_vs_set_data", conv(12'h321));
    pulse_clear();
    chk1("chan_cleared_again", chan_err, 1'b0);

    // Response while idle is ignored
    response_channel = 5'd3;
    response_data    = 12'h555;
    response_valid   = 1'b1;
    @(negedge clk);
    response_valid = 1'b0;
    @(negedge clk);
    chk1("idle_resp_no_push", sample_valid, 1'b0);
    chk1("idle_resp_no_chan_err", chan_err, 1'b0);

    // Command held while command_ready low
    command_ready = 1'b0;
    enable        = 1'b1;
    wait_cmd(t0);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk1($sformatf("cmd_held_%0d", i), command_valid, 1'b1);
      @(negedge clk);
    end
    chk1("cmd_held_last", command_valid, 1'b1);
    command_ready = 1'b1;
    @(negedge clk);
    chk1("cmd_single_accept", command_valid, 1'b0);
    response_channel = 5'd0;
    response_data    = 12'h2C4;
    response_valid   = 1'b1;
    @(negedge clk);
    response_valid = 1'b0;
    pop_chk("stall_sample", conv(12'h2C4));
    chk1("stall_one_sample", sample_valid, 1'b0);

    // Overflow: six responses with no consumer
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d = 12'h100 | 12'(k);
      do_txn(5'd0, d, (k < 5), 1'b0, 1'b0, t0);
      if (k == 3) chk1("ovf_not_yet", overflow, 1'b0);
      if (k == 4) chk1("ovf_after_fifth", overflow, 1'b1);
    end
    pulse_clear();
    chk1("ovf_cleared", overflow, 1'b0);
    chk12("full_head", sample_data, conv(12'h100));
    // Push and pop in the same cycle while full
    enable = 1'b1;
    do_txn(5'd0, 12'h7A5, 1'b0, 1'b0, 1'b1, t0);
    chk1("full_push_pop_no_ovf", overflow, 1'b0);
    for (int k = 1; k < 4; k++) pop_chk($sformatf("drain%0d", k), conv(12'h100 | 12'(k)));
    pop_chk("drain_new", conv(12'h7A5));
    chk1("drain_empty", sample_valid, 1'b0);

    // Timeout exactly 20 cycles after accept, then relaunch on the next tick
    enable = 1'b1;
    wait_cmd(t0);
    repeat (20) @(negedge clk);
    chk1("timeout_not_yet", timeout_err, 1'b0);
    @(negedge clk);
    chk1("timeout_set", timeout_err, 1'b1);
    chk1("timeout_no_push", sample_valid, 1'b0);
    repeat (2) @(negedge clk);
    chk1("relaunch_not_yet", command_valid, 1'b0);
    @(negedge clk);
    chk1("relaunch", command_valid, 1'b1);
    do_txn(5'd0, 12'h5A5, 1'b0, 1'b0, 1'b0, t0);
    pop_chk("after_timeout", conv(12'h5A5));
    pulse_clear();
    chk1("timeout_cleared", timeout_err, 1'b0);

    // Async reset mid-transaction discards FIFO contents and aborts the command
    enable = 1'b1;
    do_txn(5'd0, 12'h0F0, 1'b1, 1'b0, 1'b0, t0);
    wait_cmd(t0);
    @(negedge clk);
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    chk1("rst_mid_sample_valid", sample_valid, 1'b0);
    chk12("rst_mid_sample_data", sample_data, 12'h000);
    @(negedge clk);
    reset_n = 1'b1;
    response_valid = 1'b1;
    @(negedge clk);
    response_valid = 1'b0;
    @(negedge clk);
    chk1("rst_mid_no_late_push", sample_valid, 1'b0);
    chk1("rst_mid_cmd_idle", command_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
